hazard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_unit_fwd_compare.sv | 29 ++
 rtl/hazard_unit.sv | 128 ++++++++++++
 tb/tb_hazard_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forward selects,
// shadow-stage records and a saturating counter helper.
package hazard_pkg;

    // Widest register address a shadow record can carry; narrower AW values are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        reg_addr_t ra1;
        reg_addr_t ra2;
        logic      use1;
        logic      use2;
        reg_addr_t wa;
        logic      regwrite;
        logic      memtoreg;
        logic      pcs;
    } stage_ctl_t;

    typedef struct packed {
        reg_addr_t wa;
        logic      regwrite;
        logic      pcs;
    } retire_ctl_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] maxv;
        maxv = (33'd1 << w) - 33'd1;
        return ({1'b0, v} == maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_compare.sv
// Forward-select for one E-stage source operand against the M and W shadows.
// The PC register is never forwarded; M wins over W.
module fwd_compare
    import hazard_pkg::*;
#(
    parameter int AW = 4
) (
    input  reg_addr_t ra,
    input  logic      rd_en,
    input  reg_addr_t wa_m,
    input  logic      regwrite_m,
    input  reg_addr_t wa_w,
    input  logic      regwrite_w,
    output fwd_sel_t  sel
);

    localparam reg_addr_t PC_REG = reg_addr_t'((1 << AW) - 1);

    always_comb begin
        sel = FWD_RF;
        if (rd_en && (ra != PC_REG)) begin
            if (regwrite_m && (wa_m == ra))
                sel = FWD_MEM;
            else if (regwrite_w && (wa_w == ra))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the F/D/E/M/W ARM pipeline: shadows the
// in-flight register usage and drives forwards, stalls, flushes and event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1_d,
    input  logic [AW-1:0]    ra2_d,
    input  logic             use1_d,
    input  logic             use2_d,
    input  logic [AW-1:0]    wa_d,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             pcs_d,
    input  logic             branch_taken_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    if (AW > REG_AW_MAX) begin : g_aw_check
        $error("hazard_unit: AW exceeds REG_AW_MAX");
    end

    stage_ctl_t  e_p0;
    retire_ctl_t m_p1;
    reg_addr_t   wa_w_p2;
    logic        regwrite_w_p2;

    reg_addr_t   ra1_dx, ra2_dx, wa_dx;
    stage_ctl_t  e_next;
    logic        ldstall, pcpend;
    fwd_sel_t    fwd_a, fwd_b;

    assign ra1_dx = reg_addr_t'(ra1_d);
    assign ra2_dx = reg_addr_t'(ra2_d);
    assign wa_dx  = reg_addr_t'(wa_d);

    // ---- D stage: hazard detection against the E shadow ----
    always_comb begin
        ldstall = e_p0.memtoreg &&
                  ((use1_d && (ra1_dx == e_p0.wa)) || (use2_d && (ra2_dx == e_p0.wa)));
        pcpend  = pcs_d | e_p0.pcs | m_p1.pcs;
        stall_d = ldstall & ~branch_taken_e;
        stall_f = (ldstall | pcpend) & ~branch_taken_e;
        flush_e = ldstall | branch_taken_e;
        flush_d = (pcpend | branch_taken_e) & ~stall_d;
    end

    // A flushed E slot keeps the D addresses but carries no control, so it can never match.
    always_comb begin
        e_next.ra1      = ra1_dx;
        e_next.ra2      = ra2_dx;
        e_next.wa       = wa_dx;
        e_next.use1     = use1_d     & ~flush_e;
        e_next.use2     = use2_d     & ~flush_e;
        e_next.regwrite = regwrite_d & ~flush_e;
        e_next.memtoreg = memtoreg_d & ~flush_e;
        e_next.pcs      = pcs_d      & ~flush_e;
    end

    // ---- E stage: operand forwarding selects ----
    fwd_compare #(.AW(AW)) u_fwd_a (
        .ra         (e_p0.ra1),
        .rd_en      (e_p0.use1),
        .wa_m       (m_p1.wa),
        .regwrite_m (m_p1.regwrite),
        .wa_w       (wa_w_p2),
        .regwrite_w (regwrite_w_p2),
        .sel        (fwd_a)
    );

    fwd_compare #(.AW(AW)) u_fwd_b (
        .ra         (e_p0.ra2),
        .rd_en      (e_p0.use2),
        .wa_m       (m_p1.wa),
        .regwrite_m (m_p1.regwrite),
        .wa_w       (wa_w_p2),
        .regwrite_w (regwrite_w_p2),
        .sel        (fwd_b)
    );

    assign forward_a_e = fwd_a;
    assign forward_b_e = fwd_b;

    // ---- shadow advance D->E->M->W; reset clears only the control bits ----
    always_ff @(posedge clk) begin
        e_p0          <= e_next;
        m_p1.wa       <= e_p0.wa;
        m_p1.regwrite <= e_p0.regwrite;
        m_p1.pcs      <= e_p0.pcs;
        wa_w_p2       <= m_p1.wa;
        regwrite_w_p2 <= m_p1.regwrite;
        if (reset) begin
            e_p0.use1     <= 1'b0;
            e_p0.use2     <= 1'b0;
            e_p0.regwrite <= 1'b0;
            e_p0.memtoreg <= 1'b0;
            e_p0.pcs      <= 1'b0;
            m_p1.regwrite <= 1'b0;
            m_p1.pcs      <= 1'b0;
            regwrite_w_p2 <= 1'b0;
        end
    end

    // ---- performance counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_f)
                stall_count <= CNT_W'(sat_inc(32'(stall_count), CNT_W));
            if (flush_e | flush_d)
                flush_count <= CNT_W'(sat_inc(32'(flush_count), CNT_W));
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus random instruction
// streams, all checked against an instruction-level pipeline model.
module tb_hazard_unit;

    typedef struct {
        logic [3:0] ra1, ra2, wa;
        bit         u1, u2, rw, mr, pcs;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1_d, ra2_d, wa_d;
    logic        use1_d, use2_d, regwrite_d, memtoreg_d, pcs_d, branch_taken_e;
    logic [1:0]  forward_a_e, forward_b_e, fa2, fb2;
    logic        stall_f, stall_d, flush_d, flush_e, sf2, sd2, fd2, fe2;
    logic [15:0] stall_count, flush_count;
    logic [1:0]  sc2, fc2;

    int checks = 0;
    int failures = 0;

    // Model: instructions currently occupying E, M and W, plus raw event totals.
    ins_t e, m, w;
    int   sc_tot, fc_tot;
    ins_t nop;

    always #5 clk = ~clk;

    hazard_unit #(.AW(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .use1_d(use1_d), .use2_d(use2_d),
        .wa_d(wa_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .pcs_d(pcs_d),
        .branch_taken_e(branch_taken_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_unit #(.AW(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .use1_d(use1_d), .use2_d(use2_d),
        .wa_d(wa_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .pcs_d(pcs_d),
        .branch_taken_e(branch_taken_e),
        .forward_a_e(fa2), .forward_b_e(fb2),
        .stall_f(sf2), .stall_d(sd2), .flush_d(fd2), .flush_e(fe2),
        .stall_count(sc2), .flush_count(fc2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input logic [3:0] ra, input bit u);
        if (!u || ra == 4'd15) return 0;
        if (m.rw && m.wa == ra) return 2;
        if (w.rw && w.wa == ra) return 1;
        return 0;
    endfunction

    function automatic int cap(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic ins_t mk(input int r1, input bit u1, input int r2, input bit u2,
                                input int wa, input bit rw, input bit mr, input bit pcs);
        ins_t i;
        i.ra1 = 4'(r1); i.u1 = u1; i.ra2 = 4'(r2); i.u2 = u2;
        i.wa = 4'(wa); i.rw = rw; i.mr = mr; i.pcs = pcs;
        return i;
    endfunction

    task automatic model_reset();
        e = nop; m = nop; w = nop;
        sc_tot = 0; fc_tot = 0;
    endtask

    // One cycle with instruction d in D: drive, check everything, advance the model.
    task automatic step(input ins_t d, input bit br, input bit rst);
        bit ld, pend, xsd, xsf, xfe, xfd;
        @(negedge clk);
        ra1_d = d.ra1; ra2_d = d.ra2; use1_d = d.u1; use2_d = d.u2;
        wa_d = d.wa; regwrite_d = d.rw; memtoreg_d = d.mr; pcs_d = d.pcs;
        branch_taken_e = br; reset = rst;
        #1;
        ld   = e.mr && ((d.u1 && d.ra1 == e.wa) || (d.u2 && d.ra2 == e.wa));
        pend = d.pcs || e.pcs || m.pcs;
        xsd  = ld && !br;
        xsf  = (ld || pend) && !br;
        xfe  = ld || br;
        xfd  = (pend || br) && !xsd;
        check_val("forward_a", 32'(forward_a_e), 32'(exp_fwd(e.ra1, e.u1)));
        check_val("forward_b", 32'(forward_b_e), 32'(exp_fwd(e.ra2, e.u2)));
        check_val("stall_f", 32'(stall_f), 32'(xsf));
        check_val("stall_d", 32'(stall_d), 32'(xsd));
        check_val("flush_d", 32'(flush_d), 32'(xfd));
        check_val("flush_e", 32'(flush_e), 32'(xfe));
        check_val("stall_count", 32'(stall_count), 32'(cap(sc_tot, 65535)));
        check_val("flush_count", 32'(flush_count), 32'(cap(fc_tot, 65535)));
        check_val("stall_count_w2", 32'(sc2), 32'(cap(sc_tot, 3)));
        check_val("flush_count_w2", 32'(fc2), 32'(cap(fc_tot, 3)));
        if (rst) begin
            model_reset();
        end else begin
            w = m; m = e;
            e = xfe ? nop : d;
            sc_tot += int'(xsf);
            fc_tot += int'(xfe || xfd);
        end
    endtask

    function automatic int rand_reg();
        int p = int'($urandom_range(0, 7));
        if (p < 4) return p;
        if (p == 4) return 15;
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        ins_t add_r1, use_r1, use_r15, wr_r15, ldr_r2, add_r2r2, mov_pc, d;
        int s0, f0;
        nop      = mk(0, 0, 0, 0, 0, 0, 0, 0);
        add_r1   = mk(2, 1, 3, 1, 1, 1, 0, 0);
        use_r1   = mk(1, 1, 3, 1, 2, 1, 0, 0);
        wr_r15   = mk(2, 1, 3, 1, 15, 1, 0, 0);
        use_r15  = mk(15, 1, 15, 1, 4, 1, 0, 0);
        ldr_r2   = mk(5, 1, 0, 0, 2, 1, 1, 0);
        add_r2r2 = mk(2, 1, 2, 1, 3, 1, 0, 0);
        mov_pc   = mk(0, 1, 0, 0, 15, 1, 0, 1);

        reset = 1'b1; branch_taken_e = 1'b0;
        ra1_d = '0; ra2_d = '0; wa_d = '0;
        use1_d = 0; use2_d = 0; regwrite_d = 0; memtoreg_d = 0; pcs_d = 0;
        repeat (2) @(posedge clk);
        model_reset();

        step(nop, 0, 0);
        check_val("reset_fwd_a", 32'(forward_a_e), 0);
        check_val("reset_stall_cnt", 32'(stall_count), 0);

        // Back-to-back ALU dependency forwards from M, one gap forwards from W.
        step(add_r1, 0, 0); step(use_r1, 0, 0); step(nop, 0, 0);
        check_val("dir_fwd_mem", 32'(forward_a_e), 2);
        step(add_r1, 0, 0); step(nop, 0, 0); step(use_r1, 0, 0); step(nop, 0, 0);
        check_val("dir_fwd_wb", 32'(forward_a_e), 1);
        step(wr_r15, 0, 0); step(use_r15, 0, 0); step(nop, 0, 0);
        check_val("dir_fwd_pc", 32'(forward_a_e), 0);

        // Load-use: one stall, consumer then forwards from W on both operands.
        s0 = int'(stall_count); f0 = int'(flush_count);
        step(ldr_r2, 0, 0); step(add_r2r2, 0, 0);
        check_val("dir_ld_stall_f", 32'(stall_f), 1);
        check_val("dir_ld_flush_e", 32'(flush_e), 1);
        step(add_r2r2, 0, 0); step(nop, 0, 0);
        check_val("dir_ld_fwd_a", 32'(forward_a_e), 1);
        check_val("dir_ld_fwd_b", 32'(forward_b_e), 1);
        check_val("dir_ld_scnt", 32'(stall_count), 32'(s0 + 1));
        check_val("dir_ld_fcnt", 32'(flush_count), 32'(f0 + 1));

        // Branch taken together with a load-use hazard: branch wins.
        f0 = int'(flush_count);
        step(ldr_r2, 0, 0); step(add_r2r2, 1, 0);
        check_val("dir_br_stall_d", 32'(stall_d), 0);
        check_val("dir_br_flush_d", 32'(flush_d), 1);
        step(nop, 0, 0);
        check_val("dir_br_fcnt", 32'(flush_count), 32'(f0 + 1));

        // PC write from a fresh reset: 3 stall cycles, then 2 more load-use stalls saturate CNT_W=2.
        step(nop, 0, 1);
        step(mov_pc, 0, 0); step(nop, 0, 0); step(nop, 0, 0); step(nop, 0, 0);
        check_val("dir_pc_release", 32'(stall_f), 0);
        check_val("dir_pc_scnt", 32'(stall_count), 3);
        step(ldr_r2, 0, 0); step(add_r2r2, 0, 0); step(add_r2r2, 0, 0);
        step(ldr_r2, 0, 0); step(add_r2r2, 0, 0); step(add_r2r2, 0, 0);
        check_val("dir_sat_w16", 32'(stall_count), 5);
        check_val("dir_sat_w2", 32'(sc2), 3);

        // Reset during a PC-write stall aborts it and clears history.
        step(add_r1, 0, 0); step(mov_pc, 0, 0); step(nop, 0, 1); step(use_r1, 0, 0);
        check_val("dir_rst_stall_f", 32'(stall_f), 0);
        check_val("dir_rst_scnt", 32'(stall_count), 0);
        step(nop, 0, 0);
        check_val("dir_rst_fwd_a", 32'(forward_a_e), 0);

        for (int i = 0; i < 3000; i++) begin
            d = mk(rand_reg(), bit'($urandom_range(0, 3) != 0), rand_reg(),
                   bit'($urandom_range(0, 1)), rand_reg(), bit'($urandom_range(0, 3) != 0),
                   bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 15) == 0));
            step(d, bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
